// File: rtl/master_start_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : master_start_pkg
//  Description : Shared constants, frame/burst types and FSM state encoding
//                for the MASTER_START command loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package master_start_pkg;

  // Frame markers and command codes
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CMD_LOAD  = 8'h01;
  localparam logic [7:0] CMD_TIME  = 8'h02;

  // Payload lengths in bytes
  localparam int LEN_LOAD = 43;
  localparam int LEN_TIME = 8;

  // Shadow register holds the longest payload
  localparam int SHADOW_W = LEN_LOAD * 8;

  // Burst parameter set written to MASTER_START on a CMD_LOAD commit
  typedef struct packed {
    logic [47:0] freq;
    logic [47:0] step;
    logic [31:0] rate;
    logic [63:0] tstart;
    logic [15:0] n_impuls;
    logic [1:0]  imp_type;
    logic [31:0] ti;
    logic [31:0] tp;
    logic [31:0] tb1;
    logic [31:0] tb2;
  } burst_params_t;

  // Frame parser states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CMD     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CHK     = 2'd3
  } state_t;

  // Saturating 8-bit increment
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ms_byte_timer.sv
`default_nettype none
// ============================================================================
//  Module      : ms_byte_timer
//  Description : Inter-byte timeout counter. Counts clk cycles while enabled,
//                restarts on i_clr, and raises o_timeout on the cycle whose
//                edge would bring the count to TIMEOUT_CYC. A clear on that
//                same cycle suppresses the timeout.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                i_clr          - restart count (byte accepted)
//                i_en           - count enable (frame in progress)
//                o_timeout      - single-cycle timeout indication (comb)
//  Revision    : 1.0 - initial release
// ============================================================================
module ms_byte_timer #(
  parameter int TIMEOUT_CYC = 4800
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_hit;

  // A byte on the expiring cycle wins over the timeout
  assign w_hit     = i_en && !i_clr && (r_cnt == c_LAST);
  assign o_timeout = w_hit;

  always_ff @(posedge clk) begin
    if (rst || i_clr || !i_en || w_hit) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/master_start_loader.sv
`default_nettype none
// ============================================================================
//  Module      : master_start_loader
//  Description : Command-side writer for the MASTER_START synchronizer.
//                Parses SYNC/CMD/payload/CHK frames from a host byte stream,
//                commits burst parameters (pulsing WR_DATA) or a system time
//                preset (raising SYS_TIME_UPDATE) on a valid checksum.
//  Ports       : CLK, RESET            - 48 MHz clock, sync active-high reset
//                rx_data, rx_valid     - received byte stream
//                SYS_TIME_UPDATE_OK    - time load acknowledged
//                MEM_*                 - burst parameters (held between commits)
//                WR_DATA               - one-cycle parameter write strobe
//                SYS_TIME, SYS_TIME_UPDATE - time preset value / arm level
//                frame_ok, frame_err   - per-frame status pulses
//                err_cnt               - saturating error counter
//  Revision    : 1.0 - initial release
// ============================================================================
module master_start_loader #(
  parameter int          TIMEOUT_CYC = 4800,
  parameter logic [7:0]  SYNC_BYTE   = master_start_pkg::SYNC_BYTE
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        SYS_TIME_UPDATE_OK,
  output logic [47:0] MEM_DDS_freq,
  output logic [47:0] MEM_DDS_delta_freq,
  output logic [31:0] MEM_DDS_delta_rate,
  output logic [63:0] MEM_TIME_START,
  output logic [15:0] MEM_N_impuls,
  output logic [1:0]  MEM_TYPE_impulse,
  output logic [31:0] MEM_Interval_Ti,
  output logic [31:0] MEM_Interval_Tp,
  output logic [31:0] MEM_Tblank1,
  output logic [31:0] MEM_Tblank2,
  output logic        WR_DATA,
  output logic [63:0] SYS_TIME,
  output logic        SYS_TIME_UPDATE,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [7:0]  err_cnt
);

  import master_start_pkg::*;

  // Remaining-byte counter preloads (counts down to zero on the last byte)
  localparam logic [5:0] c_LEFT_LOAD = 6'(LEN_LOAD - 1);
  localparam logic [5:0] c_LEFT_TIME = 6'(LEN_TIME - 1);

  state_t                r_state;
  logic [7:0]            r_cmd;
  logic [7:0]            r_sum;
  logic [5:0]            r_left;
  logic [SHADOW_W-1:0]   r_shadow;
  burst_params_t         r_params;
  logic [63:0]           r_sys_time;
  logic                  r_wr_data;
  logic                  r_sys_time_update;
  logic                  r_frame_ok;
  logic                  r_frame_err;
  logic [7:0]            r_err_cnt;

  burst_params_t         w_load_params;
  logic                  w_timeout;
  logic                  w_timer_en;

  // Payload is shifted in MSB first, so the first field lands at the top.
  // The type byte occupies [135:128]; only its two LSBs are meaningful.
  assign w_load_params.freq     = r_shadow[343:296];
  assign w_load_params.step     = r_shadow[295:248];
  assign w_load_params.rate     = r_shadow[247:216];
  assign w_load_params.tstart   = r_shadow[215:152];
  assign w_load_params.n_impuls = r_shadow[151:136];
  assign w_load_params.imp_type = r_shadow[129:128];
  assign w_load_params.ti       = r_shadow[127:96];
  assign w_load_params.tp       = r_shadow[95:64];
  assign w_load_params.tb1      = r_shadow[63:32];
  assign w_load_params.tb2      = r_shadow[31:0];

  assign w_timer_en = (r_state != ST_IDLE);

  ms_byte_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_byte_timer (
    .clk       (CLK),
    .rst       (RESET),
    .i_clr     (rx_valid),
    .i_en      (w_timer_en),
    .o_timeout (w_timeout)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state           <= ST_IDLE;
      r_cmd             <= '0;
      r_sum             <= '0;
      r_left            <= '0;
      r_shadow          <= '0;
      r_params          <= '0;
      r_sys_time        <= '0;
      r_wr_data         <= 1'b0;
      r_sys_time_update <= 1'b0;
      r_frame_ok        <= 1'b0;
      r_frame_err       <= 1'b0;
      r_err_cnt         <= '0;
    end else begin
      r_wr_data   <= 1'b0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;

      // Acknowledge clears the arm level; a commit below overrides it
      if (SYS_TIME_UPDATE_OK) begin
        r_sys_time_update <= 1'b0;
      end

      // Timeout is only asserted when no byte arrives this cycle
      if (w_timeout) begin
        r_state     <= ST_IDLE;
        r_frame_err <= 1'b1;
        r_err_cnt   <= sat_inc8(r_err_cnt);
      end else if (rx_valid) begin
        case (r_state)
          ST_IDLE: begin
            if (rx_data == SYNC_BYTE) begin
              r_state <= ST_CMD;
            end
          end

          ST_CMD: begin
            r_cmd <= rx_data;
            r_sum <= rx_data;
            if (rx_data == CMD_LOAD) begin
              r_left  <= c_LEFT_LOAD;
              r_state <= ST_PAYLOAD;
            end else if (rx_data == CMD_TIME) begin
              r_left  <= c_LEFT_TIME;
              r_state <= ST_PAYLOAD;
            end else begin
              r_state     <= ST_IDLE;
              r_frame_err <= 1'b1;
              r_err_cnt   <= sat_inc8(r_err_cnt);
            end
          end

          ST_PAYLOAD: begin
            r_shadow <= {r_shadow[SHADOW_W-9:0], rx_data};
            r_sum    <= r_sum + rx_data;
            if (r_left == 6'd0) begin
              r_state <= ST_CHK;
            end else begin
              r_left <= r_left - 6'd1;
            end
          end

          ST_CHK: begin
            r_state <= ST_IDLE;
            if (rx_data == r_sum) begin
              r_frame_ok <= 1'b1;
              if (r_cmd == CMD_LOAD) begin
                r_params  <= w_load_params;
                r_wr_data <= 1'b1;
              end else begin
                r_sys_time        <= r_shadow[63:0];
                r_sys_time_update <= 1'b1;
              end
            end else begin
              r_frame_err <= 1'b1;
              r_err_cnt   <= sat_inc8(r_err_cnt);
            end
          end

          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign MEM_DDS_freq       = r_params.freq;
  assign MEM_DDS_delta_freq = r_params.step;
  assign MEM_DDS_delta_rate = r_params.rate;
  assign MEM_TIME_START     = r_params.tstart;
  assign MEM_N_impuls       = r_params.n_impuls;
  assign MEM_TYPE_impulse   = r_params.imp_type;
  assign MEM_Interval_Ti    = r_params.ti;
  assign MEM_Interval_Tp    = r_params.tp;
  assign MEM_Tblank1        = r_params.tb1;
  assign MEM_Tblank2        = r_params.tb2;
  assign WR_DATA            = r_wr_data;
  assign SYS_TIME           = r_sys_time;
  assign SYS_TIME_UPDATE    = r_sys_time_update;
  assign frame_ok           = r_frame_ok;
  assign frame_err          = r_frame_err;
  assign err_cnt            = r_err_cnt;

endmodule
`default_nettype wire
